morse_symbol_assembler: RTL and testbench
=========================================

Name: morse_symbol_assembler

Overview:
- Downstream stage of the dot/dash detector FSM.
- Consumes one-cycle symbol pulses (dot or dash) and character-gap pulses.
- Assembles symbols into a character code (pattern + length) and presents it on a valid/ready output register for a later lookup/ROM stage.
- Contains a 3-state collector FSM, a symbol counter, and a held output register with overrun/overlength error reporting.

Parameters:
- MAX_SYM, 5, maximum symbols per character; width of the pattern register.
- LEN_W, 3, width of the length field; must hold the value MAX_SYM.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- sym_valid  in  1  one-cycle pulse: a symbol was detected.
- sym_is_dash  in  1  qualifies sym_valid: 1 = dash, 0 = dot.
- char_end  in  1  one-cycle pulse: inter-character gap detected.
- word_end  in  1  one-cycle pulse: inter-word gap detected; used only with the optional feature.
- out_ready  in  1  consumer accepts the output this cycle.
- out_valid  out  1  output character held and valid.
- out_code  out  MAX_SYM  symbol pattern; first symbol at bit 0; 1 = dash; unused upper bits 0.
- out_len  out  LEN_W  number of symbols, 1..MAX_SYM (0 only for a space token).
- out_space  out  1  token is / ends with a word space (0 without the optional feature).
- err_long  out  1  one-cycle pulse: character exceeded MAX_SYM and was discarded.
- err_overrun  out  1  one-cycle pulse: completed character dropped because the output was still held.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE; collector pattern and count = 0.
  - out_valid, out_code, out_len, out_space, err_long, err_overrun = 0.
- FSM states: IDLE (count=0), COLLECT (count 1..MAX_SYM), DROP (overlength; discarding).
- IDLE:
  - sym_valid: pattern[0] = sym_is_dash, count = 1, go to COLLECT.
  - char_end alone: ignored, no output.
- COLLECT:
  - sym_valid with count < MAX_SYM: pattern[count] = sym_is_dash, count += 1.
  - sym_valid with count == MAX_SYM: go to DROP; symbol discarded.
  - char_end: emit the character (see Output), clear the collector, go to IDLE.
- DROP:
  - Further sym_valid pulses are ignored.
  - char_end: err_long pulses 1 cycle, collector cleared, go to IDLE, nothing emitted.
- Simultaneous sym_valid and char_end: the symbol is appended first, then the character closes.
  - If that append overflows, the result is err_long, not an emission.
- Output register:
  - Latency: char_end in cycle N gives out_valid=1 in cycle N+1.
  - Fields are stable while out_valid && !out_ready.
  - Transfer occurs when out_valid && out_ready; out_valid falls next cycle unless a new character loads in that same cycle (back-to-back, no bubble).
  - Emission while out_valid=1 && out_ready=0: the new character is dropped, err_overrun pulses, and the held output is unchanged.
  - Emission while out_valid=1 && out_ready=1: the new character replaces the transferred one.
- Count/length arithmetic is unsigned; the counter never wraps (saturates via the DROP state).

Optional Feature:
- Macro: MORSE_WORD_SPACE_EN.
- Defined:
  - word_end acts as char_end plus a word-space marker.
  - In COLLECT, the emitted character has out_space=1.
  - In IDLE, a space token is emitted: out_len=0, out_code=0, out_space=1.
  - In DROP, err_long pulses and a space token is emitted.
  - Overrun rules apply unchanged.
- Undefined: word_end is ignored entirely and out_space is tied to 0.

Test Plan:
- Reset: hold rst=0 mid-COLLECT (2 symbols in) with out_valid=1 -> all outputs 0 immediately; after release, char_end alone emits nothing.
- Dash,dot,dash ("K"), then char_end with out_ready=1 -> next cycle out_valid=1, out_code=5'b00101, out_len=3; out_valid=0 the following cycle.
- Six dots, then char_end -> err_long=1 for exactly one cycle, no out_valid; next dot+char_end -> out_code=0, out_len=1.
- Emit "E" (dot) with out_ready=0, then emit "T" (dash) -> err_overrun pulses; output stays out_code=0, out_len=1 until out_ready=1.
- sym_valid (dash) and char_end in the same cycle after 4 dots -> out_code=5'b10000, out_len=5.
- With MORSE_WORD_SPACE_EN: dot, dash, word_end -> out_code=2'b10, out_len=2, out_space=1; a second word_end -> out_len=0, out_space=1. Without the macro, the same stimulus -> no emission.

Source files
------------

// File: rtl/morse_symbol_assembler.sv
// morse_symbol_assembler: collects dot/dash symbol pulses into a character
// code (pattern + length) and presents it on a held valid/ready register.
// Optional build macro MORSE_WORD_SPACE_EN enables word_end handling
// (word-space marker / space token). Without it word_end is ignored and
// out_space stays 0.
module morse_symbol_assembler #(
  parameter int MAX_SYM = 5,
  parameter int LEN_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sym_valid,
  input  logic               sym_is_dash,
  input  logic               char_end,
  input  logic               word_end,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [MAX_SYM-1:0] out_code,
  output logic [LEN_W-1:0]   out_len,
  output logic               out_space,
  output logic               err_long,
  output logic               err_overrun
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DROP    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [MAX_SYM-1:0] r_pat;
  logic [MAX_SYM-1:0] w_pat_nxt;
  logic [LEN_W-1:0]   r_cnt;
  logic [LEN_W-1:0]   w_cnt_nxt;

  logic               w_close;
  logic               w_word;
  logic               w_full;
  logic [MAX_SYM-1:0] w_pat_app;
  logic [LEN_W-1:0]   w_cnt_app;

  logic               w_emit;
  logic [MAX_SYM-1:0] w_emit_code;
  logic [LEN_W-1:0]   w_emit_len;
  logic               w_emit_space;
  logic               w_err_long;
  logic               w_load;

  logic               r_valid;
  logic [MAX_SYM-1:0] r_code;
  logic [LEN_W-1:0]   r_len;
  logic               r_space;
  logic               r_err_long;
  logic               r_err_overrun;

`ifdef MORSE_WORD_SPACE_EN
  // A word gap closes the character like char_end and also marks a space.
  assign w_word  = word_end;
  assign w_close = char_end | word_end;
`else
  logic w_unused_word_end;
  assign w_unused_word_end = word_end;
  assign w_word  = 1'b0;
  assign w_close = char_end;
`endif

  // Collector already holds MAX_SYM symbols: one more overflows it.
  assign w_full    = (r_cnt == LEN_W'(MAX_SYM));
  assign w_pat_app = r_pat | (MAX_SYM'(sym_is_dash) << r_cnt);
  assign w_cnt_app = r_cnt + LEN_W'(1);

  // State and collector registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pat   <= w_pat_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, collector update and emission request; a simultaneous
  // symbol is appended before the character closes.
  always_comb begin
    w_state_nxt  = r_state;
    w_pat_nxt    = r_pat;
    w_cnt_nxt    = r_cnt;
    w_emit       = 1'b0;
    w_emit_code  = '0;
    w_emit_len   = '0;
    w_emit_space = 1'b0;
    w_err_long   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sym_valid) begin
          w_pat_nxt   = MAX_SYM'(sym_is_dash);
          w_cnt_nxt   = LEN_W'(1);
          w_state_nxt = S_COLLECT;
        end
        if (w_close) begin
          if (sym_valid) begin
            w_emit       = 1'b1;
            w_emit_code  = MAX_SYM'(sym_is_dash);
            w_emit_len   = LEN_W'(1);
            w_emit_space = w_word;
          end else if (w_word) begin
            w_emit       = 1'b1;
            w_emit_space = 1'b1;
          end
          w_pat_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (sym_valid) begin
          if (w_full) begin
            w_state_nxt = S_DROP;
          end else begin
            w_pat_nxt = w_pat_app;
            w_cnt_nxt = w_cnt_app;
          end
        end
        if (w_close) begin
          if (sym_valid && w_full) begin
            w_err_long   = 1'b1;
            w_emit       = w_word;
            w_emit_space = w_word;
          end else begin
            w_emit       = 1'b1;
            w_emit_code  = sym_valid ? w_pat_app : r_pat;
            w_emit_len   = sym_valid ? w_cnt_app : r_cnt;
            w_emit_space = w_word;
          end
          w_pat_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        if (w_close) begin
          w_err_long   = 1'b1;
          w_emit       = w_word;
          w_emit_space = w_word;
          w_pat_nxt    = '0;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_IDLE;
        end
      end
      default: begin
        w_pat_nxt   = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // A new character loads when the register is empty or being transferred.
  assign w_load = w_emit && (!r_valid || out_ready);

  // Held output register with overrun detection and error pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid       <= 1'b0;
      r_code        <= '0;
      r_len         <= '0;
      r_space       <= 1'b0;
      r_err_long    <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_err_long    <= w_err_long;
      r_err_overrun <= w_emit && r_valid && !out_ready;
      if (w_load) begin
        r_valid <= 1'b1;
        r_code  <= w_emit_code;
        r_len   <= w_emit_len;
        r_space <= w_emit_space;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_valid;
  assign out_code    = r_code;
  assign out_len     = r_len;
  assign out_space   = r_space;
  assign err_long    = r_err_long;
  assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_morse_symbol_assembler.sv
// Directed bench for morse_symbol_assembler: per-cycle vector table plus
// a hand-written asynchronous reset sequence.
module tb_morse_symbol_assembler;

  logic       clk;
  logic       rst;
  logic       sym_valid;
  logic       sym_is_dash;
  logic       char_end;
  logic       word_end;
  logic       out_ready;
  logic       out_valid;
  logic [4:0] out_code;
  logic [2:0] out_len;
  logic       out_space;
  logic       err_long;
  logic       err_overrun;

  int checks = 0;
  int errors = 0;

  morse_symbol_assembler #(.MAX_SYM(5), .LEN_W(3)) dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_is_dash(sym_is_dash),
    .char_end(char_end), .word_end(word_end), .out_ready(out_ready),
    .out_valid(out_valid), .out_code(out_code), .out_len(out_len),
    .out_space(out_space), .err_long(err_long), .err_overrun(err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sv;
    logic       dash;
    logic       ce;
    logic       we;
    logic       rdy;
    logic       ev;
    logic [4:0] ecode;
    logic [2:0] elen;
    logic       espace;
    logic       eel;
    logic       eeo;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic sv, logic dash, logic ce, logic we, logic rdy,
                              logic ev, logic [4:0] ecode, logic [2:0] elen,
                              logic espace, logic eel, logic eeo);
    vec_t v;
    v.sv = sv; v.dash = dash; v.ce = ce; v.we = we; v.rdy = rdy;
    v.ev = ev; v.ecode = ecode; v.elen = elen; v.espace = espace;
    v.eel = eel; v.eeo = eeo;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic sv, input logic dash, input logic ce,
                       input logic we, input logic rdy);
    @(negedge clk);
    sym_valid = sv; sym_is_dash = dash; char_end = ce; word_end = we; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    chk({tag, ".valid"}, int'(out_valid), int'(v.ev));
    chk({tag, ".err_long"}, int'(err_long), int'(v.eel));
    chk({tag, ".err_overrun"}, int'(err_overrun), int'(v.eeo));
    if (v.ev) begin
      chk({tag, ".code"}, int'(out_code), int'(v.ecode));
      chk({tag, ".len"}, int'(out_len), int'(v.elen));
      chk({tag, ".space"}, int'(out_space), int'(v.espace));
    end
  endtask

  initial begin
    // Inputs: sv dash ce we rdy | expected after the edge: valid code len space el eo
    // "K" = dash dot dash
    vq.push_back(mk(1,1,0,0,1, 0,5'd0,3'd0,0,0,0));
    vq.push_back(mk(1,0,0,0,1, 0,5'd0,3'd0,0,0,0));
    vq.push_back(mk(1,1,0,0,1, 0,5'd0,3'd0,0,0,0));
    vq.push_back(mk(0,0,1,0,1, 1,5'b00101,3'd3,0,0,0));
    vq.push_back(mk(0,0,0,0,1, 0,5'd0,3'd0,0,0,0));
    // Six dots, then char_end: overlength
    for (int i = 0; i < 6; i++) vq.push_back(mk(1,0,0,0,1, 0,5'd0,3'd0,0,0,0));
    vq.push_back(mk(0,0,1,0,1, 0,5'd0,3'd0,0,1,0));
    vq.push_back(mk(0,0,0,0,1, 0,5'd0,3'd0,0,0,0));
    vq.push_back(mk(1,0,0,0,1, 0,5'd0,3'd0,0,0,0));
    vq.push_back(mk(0,0,1,0,1, 1,5'd0,3'd1,0,0,0));
    vq.push_back(mk(0,0,0,0,1, 0,5'd0,3'd0,0,0,0));
    // "E" held with ready low, then "T" overruns
    vq.push_back(mk(1,0,0,0,0, 0,5'd0,3'd0,0,0,0));
    vq.push_back(mk(0,0,1,0,0, 1,5'd0,3'd1,0,0,0));
    vq.push_back(mk(1,1,0,0,0, 1,5'd0,3'd1,0,0,0));
    vq.push_back(mk(0,0,1,0,0, 1,5'd0,3'd1,0,0,1));
    vq.push_back(mk(0,0,0,0,0, 1,5'd0,3'd1,0,0,0));
    vq.push_back(mk(0,0,0,0,1, 0,5'd0,3'd0,0,0,0));
    // Back-to-back: new character replaces the one being transferred
    vq.push_back(mk(1,0,0,0,1, 0,5'd0,3'd0,0,0,0));
    vq.push_back(mk(0,0,1,0,0, 1,5'd0,3'd1,0,0,0));
    vq.push_back(mk(1,1,0,0,0, 1,5'd0,3'd1,0,0,0));
    vq.push_back(mk(0,0,1,0,1, 1,5'd1,3'd1,0,0,0));
    vq.push_back(mk(0,0,0,0,1, 0,5'd0,3'd0,0,0,0));
    // Four dots, then dash with char_end together
    for (int i = 0; i < 4; i++) vq.push_back(mk(1,0,0,0,1, 0,5'd0,3'd0,0,0,0));
    vq.push_back(mk(1,1,1,0,1, 1,5'b10000,3'd5,0,0,0));
    vq.push_back(mk(0,0,0,0,1, 0,5'd0,3'd0,0,0,0));
    // Five dots, then a sixth with char_end together: overflow
    for (int i = 0; i < 5; i++) vq.push_back(mk(1,0,0,0,1, 0,5'd0,3'd0,0,0,0));
    vq.push_back(mk(1,0,1,0,1, 0,5'd0,3'd0,0,1,0));
    vq.push_back(mk(0,0,0,0,1, 0,5'd0,3'd0,0,0,0));
    // Idle: dash with char_end together gives "T"
    vq.push_back(mk(1,1,1,0,1, 1,5'd1,3'd1,0,0,0));
    vq.push_back(mk(0,0,0,0,1, 0,5'd0,3'd0,0,0,0));
    // dot, dash, word_end, then a second word_end, then char_end
    vq.push_back(mk(1,0,0,0,1, 0,5'd0,3'd0,0,0,0));
    vq.push_back(mk(1,1,0,0,1, 0,5'd0,3'd0,0,0,0));
`ifdef MORSE_WORD_SPACE_EN
    vq.push_back(mk(0,0,0,1,1, 1,5'b00010,3'd2,1,0,0));
    vq.push_back(mk(0,0,0,0,1, 0,5'd0,3'd0,0,0,0));
    vq.push_back(mk(0,0,0,1,1, 1,5'd0,3'd0,1,0,0));
    vq.push_back(mk(0,0,0,0,1, 0,5'd0,3'd0,0,0,0));
    vq.push_back(mk(0,0,1,0,1, 0,5'd0,3'd0,0,0,0));
`else
    vq.push_back(mk(0,0,0,1,1, 0,5'd0,3'd0,0,0,0));
    vq.push_back(mk(0,0,0,0,1, 0,5'd0,3'd0,0,0,0));
    vq.push_back(mk(0,0,0,1,1, 0,5'd0,3'd0,0,0,0));
    vq.push_back(mk(0,0,0,0,1, 0,5'd0,3'd0,0,0,0));
    vq.push_back(mk(0,0,1,0,1, 1,5'b00010,3'd2,0,0,0));
`endif
    vq.push_back(mk(0,0,0,0,1, 0,5'd0,3'd0,0,0,0));

    sym_valid = 0; sym_is_dash = 0; char_end = 0; word_end = 0; out_ready = 0;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid", int'(out_valid), 0);
    chk("reset.code", int'(out_code), 0);
    chk("reset.len", int'(out_len), 0);
    chk("reset.space", int'(out_space), 0);
    chk("reset.err_long", int'(err_long), 0);
    chk("reset.err_overrun", int'(err_overrun), 0);
    @(negedge clk);
    rst = 1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].sv, vq[i].dash, vq[i].ce, vq[i].we, vq[i].rdy);
      check_outs($sformatf("vec%0d", i), vq[i]);
    end

    // Asynchronous reset mid-COLLECT with an output held.
    drive(1,0,0,0,0);
    drive(0,0,1,0,0);
    chk("arst.pre_valid", int'(out_valid), 1);
    drive(1,1,0,0,0);
    drive(1,1,0,0,0);
    @(negedge clk);
    sym_valid = 0; sym_is_dash = 0; char_end = 0; word_end = 0; out_ready = 0;
    #2;
    rst = 0;
    #1;
    chk("arst.valid", int'(out_valid), 0);
    chk("arst.code", int'(out_code), 0);
    chk("arst.len", int'(out_len), 0);
    chk("arst.space", int'(out_space), 0);
    chk("arst.err_long", int'(err_long), 0);
    chk("arst.err_overrun", int'(err_overrun), 0);
    @(negedge clk);
    rst = 1;
    drive(0,0,1,0,1);
    chk("post_rst.ce_valid", int'(out_valid), 0);
    drive(0,0,0,0,1);
    chk("post_rst.idle_valid", int'(out_valid), 0);
    drive(1,0,0,0,1);
    drive(0,0,1,0,1);
    chk("post_rst.valid", int'(out_valid), 1);
    chk("post_rst.code", int'(out_code), 0);
    chk("post_rst.len", int'(out_len), 1);
    drive(0,0,0,0,1);
    chk("post_rst.drain", int'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
